// File: rtl/tenths_countdown_pkg.sv
// Shared types and constants for the seconds.tenths countdown block.
// Holds the FSM encoding, the BCD digit limit and the load clamp helper.
package tenths_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [3:0] tenths;
    } bcd_time_t;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
        return (nib > BCD_NINE) ? BCD_NINE : nib;
    endfunction

endpackage

// File: rtl/tenths_countdown_if.sv
// Control/status bundle between the tick generator, game FSM and the countdown.
// The master drives the controls; the countdown (slave) drives the status.
interface tenths_countdown_if;
    logic       hundred_ms_tick;
    logic       load;
    logic [7:0] load_sec;
    logic       start;
    logic       stop;
    logic       tick_enable;
    logic [7:0] sec_bcd;
    logic [3:0] tenths_bcd;
    logic       running;
    logic       time_up;

    modport master (
        output hundred_ms_tick, load, load_sec, start, stop,
        input  tick_enable, sec_bcd, tenths_bcd, running, time_up
    );

    modport slave (
        input  hundred_ms_tick, load, load_sec, start, stop,
        output tick_enable, sec_bcd, tenths_bcd, running, time_up
    );
endinterface

// File: rtl/tenths_countdown_bcd_down_digit.sv
// One BCD digit of a ripple-borrow down counter.
// A borrow into a zero digit wraps it to nine and passes the borrow on.
module bcd_down_digit
    import tenths_countdown_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_borrow_in,
    output logic [3:0] o_digit_next,
    output logic       o_borrow_out
);

    logic w_is_zero;

    assign w_is_zero    = (i_digit == 4'd0);
    assign o_digit_next = !i_borrow_in ? i_digit :
                          (w_is_zero ? BCD_NINE : i_digit - 4'd1);
    assign o_borrow_out = i_borrow_in & w_is_zero;

endmodule

// File: rtl/tenths_countdown.sv
// BCD seconds.tenths countdown driven by the 100 ms tick stream.
// Holds the run/pause/expire FSM, the load clamp and the one-cycle expiry pulse.
module tenths_countdown
    import tenths_countdown_pkg::*;
#(
    parameter logic [7:0] INIT_SEC    = 8'h30,
    parameter logic [3:0] INIT_TENTHS = 4'h0
)(
    input  logic               clk,
    input  logic               rst,
    tenths_countdown_if.slave  bus
);

    state_t    r_state;
    state_t    w_state_next;
    bcd_time_t r_time;
    bcd_time_t w_time_dec;
    logic      w_tenths_borrow;
    logic      w_ones_borrow;
    logic      w_is_zero;
    logic      w_is_last;
    logic      w_do_dec;
    logic      r_time_up;

    bcd_down_digit u_tenths (
        .i_digit      (r_time.tenths),
        .i_borrow_in  (1'b1),
        .o_digit_next (w_time_dec.tenths),
        .o_borrow_out (w_tenths_borrow)
    );

    bcd_down_digit u_ones (
        .i_digit      (r_time.ones),
        .i_borrow_in  (w_tenths_borrow),
        .o_digit_next (w_time_dec.ones),
        .o_borrow_out (w_ones_borrow)
    );

    // A borrow surviving past the tens digit means every digit was zero.
    bcd_down_digit u_tens (
        .i_digit      (r_time.tens),
        .i_borrow_in  (w_ones_borrow),
        .o_digit_next (w_time_dec.tens),
        .o_borrow_out (w_is_zero)
    );

    assign w_is_last = (w_time_dec == bcd_time_t'(12'h000));
    assign w_do_dec  = (r_state == ST_RUN) && bus.hundred_ms_tick &&
                       !bus.load && !w_is_zero;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the default assignment up front keeps this block free of latches
    // on paths that do not change state.
    always_comb begin
        w_state_next = r_state;
        if (bus.load) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (bus.start && !bus.stop && !w_is_zero) w_state_next = ST_RUN;
                ST_RUN: begin
                    if (bus.hundred_ms_tick && w_is_last) w_state_next = ST_EXPIRED;
                    else if (bus.stop)                    w_state_next = ST_PAUSED;
                end
                ST_PAUSED:  if (bus.start && !bus.stop) w_state_next = ST_RUN;
                ST_EXPIRED: w_state_next = ST_EXPIRED;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.running     = 1'b0;
        bus.tick_enable = 1'b0;
        if (r_state == ST_RUN) begin
            bus.running     = 1'b1;
            bus.tick_enable = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time    <= {INIT_SEC, INIT_TENTHS};
            r_time_up <= 1'b0;
        end else begin
            if (bus.load)
                r_time <= {clamp_bcd(bus.load_sec[7:4]), clamp_bcd(bus.load_sec[3:0]), 4'h0};
            else if (w_do_dec)
                r_time <= w_time_dec;
            r_time_up <= (w_state_next == ST_EXPIRED) && (r_state != ST_EXPIRED);
        end
    end

    assign bus.sec_bcd    = {r_time.tens, r_time.ones};
    assign bus.tenths_bcd = r_time.tenths;
    assign bus.time_up    = r_time_up;

endmodule

// File: tb/tb_tenths_countdown.sv
// Bench for tenths_countdown: directed table, corner sequences, random vs model.
// The model keeps the count as an integer number of tenths.
module tb_tenths_countdown;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #10 clk = ~clk;

    tenths_countdown_if bus ();

    tenths_countdown #(
        .INIT_SEC    (8'h30),
        .INIT_TENTHS (4'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mode_t;
    int    m_val;
    mode_t m_mode;
    bit    m_tu;

    typedef struct {
        bit         r, ld;
        logic [7:0] ls;
        bit         tk, st, sp;
        logic [7:0] e_sec;
        logic [3:0] e_ten;
        bit         e_run, e_tu;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_step(input bit r, input bit ld, input logic [7:0] ls,
                              input bit tk, input bit st, input bit sp);
        m_tu = 1'b0;
        if (r) begin
            m_val  = 300;
            m_mode = M_IDLE;
        end else if (ld) begin
            m_val  = clamp9(int'(ls[7:4])) * 100 + clamp9(int'(ls[3:0])) * 10;
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:   if (st && !sp && m_val != 0) m_mode = M_RUN;
                M_RUN: begin
                    if (tk) begin
                        m_val = m_val - 1;
                        if (m_val == 0) begin
                            m_mode = M_EXPIRED;
                            m_tu   = 1'b1;
                        end else if (sp) m_mode = M_PAUSED;
                    end else if (sp) m_mode = M_PAUSED;
                end
                M_PAUSED: if (st && !sp) m_mode = M_RUN;
                default:  ;
            endcase
        end
    endtask

    task automatic cycle(input bit r, input bit ld, input logic [7:0] ls,
                         input bit tk, input bit st, input bit sp);
        rst                 = r;
        bus.load            = ld;
        bus.load_sec        = ls;
        bus.hundred_ms_tick = tk;
        bus.start           = st;
        bus.stop            = sp;
        @(posedge clk);
        model_step(r, ld, ls, tk, st, sp);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] s, input logic [3:0] t,
                             input bit run, input bit tu);
        check({tag, " sec"},         bus.sec_bcd,     s);
        check({tag, " tenths"},      bus.tenths_bcd,  t);
        check({tag, " running"},     bus.running,     run);
        check({tag, " tick_enable"}, bus.tick_enable, run);
        check({tag, " time_up"},     bus.time_up,     tu);
    endtask

    task automatic check_model(input string tag);
        logic [7:0] es;
        logic [3:0] et;
        es = 8'(((m_val / 100) << 4) | ((m_val / 10) % 10));
        et = 4'(m_val % 10);
        check_out(tag, es, et, m_mode == M_RUN, m_tu);
    endtask

    function automatic vec_t mk(input bit r, input bit ld, input logic [7:0] ls,
                                input bit tk, input bit st, input bit sp,
                                input logic [7:0] e_sec, input logic [3:0] e_ten,
                                input bit e_run, input bit e_tu);
        vec_t x;
        x.r = r; x.ld = ld; x.ls = ls; x.tk = tk; x.st = st; x.sp = sp;
        x.e_sec = e_sec; x.e_ten = e_ten; x.e_run = e_run; x.e_tu = e_tu;
        return x;
    endfunction

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.load_sec = 8'h00; bus.hundred_ms_tick = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0;

        // r, ld, ls, tk, st, sp, exp sec, exp tenths, exp running, exp time_up
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h30, 4'h0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h30, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h30, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h10, 0, 0, 0, 8'h10, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h10, 4'h0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h09, 4'h9, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h09, 4'h8, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h09, 4'h8, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h09, 4'h8, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h09, 4'h8, 1, 0));
        vecs.push_back(mk(0, 1, 8'h9F, 0, 0, 0, 8'h99, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h99, 4'h0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h20, 1, 0, 0, 8'h20, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 8'h95, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h13, 0, 0, 0, 8'h13, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h13, 4'h0, 1, 0));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h12, 4'(9 - i), 1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h30, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h30, 4'h0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h30, 4'h0, 0, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].ld, vecs[i].ls, vecs[i].tk, vecs[i].st, vecs[i].sp);
            check_out($sformatf("vec%0d", i), vecs[i].e_sec, vecs[i].e_ten, vecs[i].e_run, vecs[i].e_tu);
        end

        // 01.0 counts out over ten ticks with idle gaps; one expiry pulse.
        cycle(0, 1, 8'h01, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 8'h00, 1, 0, 0);
            if (i == 8) check_out("t2 at 00.1", 8'h00, 4'h1, 1, 0);
            if (i < 9) begin
                cycle(0, 0, 8'h00, 0, 0, 0);
                check({$sformatf("t2 gap%0d", i), " time_up"}, bus.time_up, 0);
            end
        end
        check_out("t2 expire", 8'h00, 4'h0, 0, 1);
        cycle(0, 0, 8'h00, 0, 0, 0);
        check_out("t2 after", 8'h00, 4'h0, 0, 0);
        cycle(0, 0, 8'h00, 1, 1, 0);
        check_out("t2 start ignored", 8'h00, 4'h0, 0, 0);

        // Tick and stop together pause after the decrement.
        cycle(0, 1, 8'h05, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 1, 0);
        cycle(0, 0, 8'h00, 1, 0, 1);
        check_out("t4 tick+stop", 8'h04, 4'h9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'h00, 1, 0, 0);
            check_out($sformatf("t4 paused tick%0d", i), 8'h04, 4'h9, 0, 0);
        end
        cycle(0, 0, 8'h00, 0, 1, 0);
        check_out("t4 resume", 8'h04, 4'h9, 1, 0);
        cycle(0, 0, 8'h00, 1, 0, 0);
        check_out("t4 tick", 8'h04, 4'h8, 1, 0);

        // Final tick together with stop still expires.
        cycle(0, 1, 8'h01, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 8'h00, 1, 0, 0);
        cycle(0, 0, 8'h00, 1, 0, 1);
        check_out("last tick+stop", 8'h00, 4'h0, 0, 1);

        cycle(1, 0, 8'h00, 0, 0, 0);
        check_model("rnd reset");
        for (int n = 0; n < 4000; n++) begin
            bit         r, ld, tk, st, sp;
            logic [7:0] ls;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 49) == 0);
            ls = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            tk = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 19) == 0);
            cycle(r, ld, ls, tk, st, sp);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
